adder_arbiter: RTL and testbench

Round-robin controller that shares one pipelined `ADDER` instance (`ADD_BIT`-wide, two-cycle registered latency, sticky `out_valid`) among `NUM_REQ` requesters. It owns the adder's `enable` line and runs a start-up sequence to bring the adder on line. It accepts at most one operand pair per cycle and tags each operation through the adder pipeline. It returns each sum plus carry to the requester that issued it, in issue order.

---
 rtl/adder_arbiter_if.sv | 30 +++
 rtl/adder_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_adder_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_arbiter_if.sv
// Requester-side bundle of adder_arbiter: packed operand requests and tagged sum responses.
interface adder_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADD_BIT = 16
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*ADD_BIT-1:0] req_A;
    logic [NUM_REQ*ADD_BIT-1:0] req_B;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [ADD_BIT:0]           rsp_data;

    modport master (
        output req_valid,
        output req_A,
        output req_B,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_A,
        input  req_B,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one two-cycle pipelined ADDER among NUM_REQ requesters,
// with adder start-up sequencing and one-hot tags that route each sum back to its issuer.
module adder_arbiter #(
    parameter int ADD_BIT = 16,
    parameter int NUM_REQ = 4,
    parameter int ADD_LAT = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               hold,
    adder_arbiter_if.slave     bus,
    output logic               add_enable,
    output logic [ADD_BIT-1:0] add_A,
    output logic [ADD_BIT-1:0] add_B,
    input  logic               add_out_valid,
    input  logic [ADD_BIT:0]   add_Dout,
    output logic               busy,
    output logic [15:0]        op_count
);
    localparam int               PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0]   REQ_LIM = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_INIT  = 2'd1,
        S_WAIT  = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t                            state_r;
    logic                              add_enable_r;
    logic [PTR_W-1:0]                  ptr_r;
    logic [ADD_BIT-1:0]                add_a_r;
    logic [ADD_BIT-1:0]                add_b_r;
    logic                              issue_vld_r;
    logic [NUM_REQ-1:0]                issue_tag_r;
    logic [ADD_LAT-1:0]                tag_vld_r;
    logic [ADD_LAT-1:0][NUM_REQ-1:0]   tag_pipe_r;
    logic [NUM_REQ-1:0]                rsp_valid_r;
    logic [ADD_BIT:0]                  rsp_data_r;
    logic [15:0]                       op_count_r;

    logic                              grant_found_s;
    logic [PTR_W-1:0]                  grant_idx_s;
    logic [NUM_REQ-1:0]                grant_oh_s;
    logic                              transfer_s;
    logic [ADD_BIT-1:0]                sel_a_s;
    logic [ADD_BIT-1:0]                sel_b_s;
    logic [PTR_W-1:0]                  ptr_next_s;

    // Start-up sequencer: pulse adder enable once, then wait for its sticky out_valid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= S_RESET;
            add_enable_r <= 1'b0;
        end else begin
            case (state_r)
                S_RESET: begin
                    state_r      <= S_INIT;
                    add_enable_r <= 1'b1;
                end
                S_INIT: begin
                    state_r      <= S_WAIT;
                    add_enable_r <= 1'b0;
                end
                S_WAIT: begin
                    add_enable_r <= 1'b0;
                    if (add_out_valid) begin
                        state_r <= S_RUN;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_RUN: begin
                    state_r      <= S_RUN;
                    add_enable_r <= 1'b0;
                end
                default: begin
                    state_r      <= S_RESET;
                    add_enable_r <= 1'b0;
                end
            endcase
        end
    end

    // Round-robin pick: scan offsets high to low so the nearest requester at/after ptr wins.
    always_comb begin
        logic [PTR_W:0] cand_s;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        grant_oh_s    = '0;
        cand_s        = '0;
        if ((state_r == S_RUN) && !hold) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                cand_s = {1'b0, ptr_r} + (PTR_W+1)'(i);
                if (cand_s >= REQ_LIM) begin
                    cand_s = cand_s - REQ_LIM;
                end else begin
                    cand_s = cand_s;
                end
                if (bus.req_valid[cand_s[PTR_W-1:0]]) begin
                    grant_found_s = 1'b1;
                    grant_idx_s   = cand_s[PTR_W-1:0];
                end else begin
                    grant_found_s = grant_found_s;
                end
            end
        end else begin
            grant_found_s = 1'b0;
        end
        if (grant_found_s) begin
            grant_oh_s[grant_idx_s] = 1'b1;
        end else begin
            grant_oh_s = '0;
        end
    end

    // Operand mux driven by the one-hot grant, plus the pointer that follows a transfer.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_a_s = sel_a_s | ({ADD_BIT{grant_oh_s[i]}} & bus.req_A[i*ADD_BIT +: ADD_BIT]);
            sel_b_s = sel_b_s | ({ADD_BIT{grant_oh_s[i]}} & bus.req_B[i*ADD_BIT +: ADD_BIT]);
        end
        if (grant_idx_s == PTR_MAX) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = grant_idx_s + PTR_W'(1);
        end
    end

    assign transfer_s = |(bus.req_valid & grant_oh_s);

    // Issue register, tag pipeline aligned with the adder stages, and response capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_r       <= '0;
            add_a_r     <= '0;
            add_b_r     <= '0;
            issue_vld_r <= 1'b0;
            issue_tag_r <= '0;
            tag_vld_r   <= '0;
            tag_pipe_r  <= '0;
            rsp_valid_r <= '0;
            rsp_data_r  <= '0;
            op_count_r  <= 16'd0;
        end else begin
            if (transfer_s) begin
                ptr_r   <= ptr_next_s;
                add_a_r <= sel_a_s;
                add_b_r <= sel_b_s;
            end else begin
                ptr_r   <= ptr_r;
                add_a_r <= add_a_r;
                add_b_r <= add_b_r;
            end
            issue_vld_r   <= transfer_s;
            issue_tag_r   <= transfer_s ? grant_oh_s : '0;
            tag_vld_r[0]  <= issue_vld_r;
            tag_pipe_r[0] <= issue_tag_r;
            for (int s = ADD_LAT - 1; s > 0; s--) begin
                tag_vld_r[s]  <= tag_vld_r[s-1];
                tag_pipe_r[s] <= tag_pipe_r[s-1];
            end
            // Dout is stable for the whole cycle the oldest tag sits at the pipeline end.
            if (tag_vld_r[ADD_LAT-1]) begin
                rsp_valid_r <= tag_pipe_r[ADD_LAT-1];
                rsp_data_r  <= add_Dout;
                op_count_r  <= op_count_r + 16'd1;
            end else begin
                rsp_valid_r <= '0;
                rsp_data_r  <= rsp_data_r;
                op_count_r  <= op_count_r;
            end
        end
    end

    assign bus.req_ready = grant_oh_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign add_enable    = add_enable_r;
    assign add_A         = add_a_r;
    assign add_B         = add_b_r;
    assign op_count      = op_count_r;
    assign busy          = issue_vld_r | (|tag_vld_r) | (|rsp_valid_r);

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: behavioural ADDER, queue-based response model, directed scenarios.
module tb_adder_arbiter;
    localparam int NR = 4;
    localparam int AB = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          hold = 1'b0;
    logic          add_enable;
    logic [AB-1:0] add_A;
    logic [AB-1:0] add_B;
    logic          add_out_valid;
    logic [AB:0]   add_Dout;
    logic          busy;
    logic [15:0]   op_count;

    always #5 clk = ~clk;

    adder_arbiter_if #(.NUM_REQ(NR), .ADD_BIT(AB)) bus ();

    adder_arbiter #(.ADD_BIT(AB), .NUM_REQ(NR), .ADD_LAT(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .hold         (hold),
        .bus          (bus),
        .add_enable   (add_enable),
        .add_A        (add_A),
        .add_B        (add_B),
        .add_out_valid(add_out_valid),
        .add_Dout     (add_Dout),
        .busy         (busy),
        .op_count     (op_count)
    );

    // Behavioural ADDER: enable takes two edges to arm, out_valid one more; data two edges.
    logic          en_s1;
    logic          en_ff;
    logic [AB-1:0] a_q;
    logic [AB-1:0] b_q;
    always @(posedge clk) begin
        if (!reset_n) begin
            en_s1 <= 1'b0; en_ff <= 1'b0; add_out_valid <= 1'b0;
            a_q <= '0; b_q <= '0; add_Dout <= '0;
        end else begin
            en_s1         <= add_enable;
            en_ff         <= en_ff | en_s1;
            add_out_valid <= add_out_valid | en_ff;
            a_q           <= add_A;
            b_q           <= add_B;
            add_Dout      <= {1'b0, a_q} + {1'b0, b_q};
        end
    end

    typedef struct {
        int          due;
        logic [NR-1:0] oh;
        logic [AB:0] sum;
    } rsp_t;

    int            checks = 0;
    int            failures = 0;
    int            edge_cnt = 0;
    int            n_up = 0;
    int            m_ptr = 0;
    int            en_cnt = 0;
    logic [15:0]   m_count = 16'd0;
    logic [AB:0]   m_last = '0;
    logic [AB-1:0] m_a = '0;
    logic [AB-1:0] m_b = '0;
    rsp_t          q[$];
    int            dut_grants[$];
    logic [NR-1:0] dut_rsp_oh[$];
    logic [AB:0]   dut_rsp_data[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h edge=%0d", name, act, exp, edge_cnt);
        end
    endtask

    // One clock cycle: compare DUT against the model, then advance the model over the edge.
    task automatic tick();
        logic [NR-1:0] e_ready;
        logic [NR-1:0] e_rv;
        logic          e_busy;
        rsp_t          item;
        int            g;
        #1;
        e_ready = '0;
        g = -1;
        if (n_up >= 5 && !hold) begin
            for (int off = 0; off < NR; off++) begin
                int idx;
                idx = (m_ptr + off) % NR;
                if (g < 0 && bus.req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) e_ready[g] = 1'b1;
        e_busy = (q.size() != 0);
        e_rv = '0;
        if (q.size() != 0 && q[0].due == edge_cnt) begin
            e_rv    = q[0].oh;
            m_last  = q[0].sum;
            m_count = m_count + 16'd1;
            void'(q.pop_front());
        end
        chk("req_ready", 64'(bus.req_ready), 64'(e_ready));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(e_rv));
        chk("rsp_data", 64'(bus.rsp_data), 64'(m_last));
        chk("op_count", 64'(op_count), 64'(m_count));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("add_enable", 64'(add_enable), 64'(n_up == 1));
        chk("add_A", 64'(add_A), 64'(m_a));
        chk("add_B", 64'(add_B), 64'(m_b));
        if (add_enable === 1'b1) en_cnt++;
        for (int i = 0; i < NR; i++) begin
            if (reset_n && bus.req_ready[i] && bus.req_valid[i]) dut_grants.push_back(i);
        end
        if (bus.rsp_valid != '0) begin
            dut_rsp_oh.push_back(bus.rsp_valid);
            dut_rsp_data.push_back(bus.rsp_data);
        end
        if (!reset_n) begin
            q.delete();
            m_ptr = 0; m_count = 16'd0; m_last = '0; m_a = '0; m_b = '0;
        end else if (g >= 0) begin
            m_a      = bus.req_A[g*AB +: AB];
            m_b      = bus.req_B[g*AB +: AB];
            item.due = edge_cnt + 4;
            item.oh  = e_ready;
            item.sum = {1'b0, m_a} + {1'b0, m_b};
            q.push_back(item);
            m_ptr = (g + 1) % NR;
        end
        @(posedge clk);
        edge_cnt++;
        n_up = reset_n ? ((n_up < 100) ? n_up + 1 : n_up) : 0;
        @(negedge clk);
    endtask

    task automatic chk_grants(input string name, input int exp[$]);
        chk({name, "_count"}, 64'(dut_grants.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            chk(name, 64'((i < dut_grants.size()) ? dut_grants[i] : -1), 64'(exp[i]));
        end
    endtask

    initial begin
        int exp_g[$];
        bus.req_valid = '0;
        bus.req_A = {16'h0000, 16'h8000, 16'h1234, 16'hFFFF};
        bus.req_B = {16'h0000, 16'h8000, 16'h4321, 16'h0002};
        repeat (3) @(posedge clk);
        @(negedge clk);

        // start-up with every requester asking, then 8 cycles of round-robin
        reset_n = 1'b1;
        bus.req_valid = 4'hF;
        repeat (5) tick();
        chk("startup_first_grant", 64'(bus.req_ready), 64'(4'b0001));
        chk("startup_enable_pulses", 64'(en_cnt), 64'd1);
        repeat (8) tick();
        bus.req_valid = '0;
        repeat (5) tick();
        exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};
        chk_grants("rr_grant", exp_g);
        chk("rr_rsp_count", 64'(dut_rsp_oh.size()), 64'd8);
        if (dut_rsp_oh.size() >= 4) begin
            chk("rr_rsp_oh0", 64'(dut_rsp_oh[0]), 64'(4'b0001));
            chk("rr_rsp_oh3", 64'(dut_rsp_oh[3]), 64'(4'b1000));
            chk("rr_sum0", 64'(dut_rsp_data[0]), 64'(17'h10001));
            chk("rr_sum1", 64'(dut_rsp_data[1]), 64'(17'h05555));
            chk("rr_sum2", 64'(dut_rsp_data[2]), 64'(17'h10000));
            chk("rr_sum3", 64'(dut_rsp_data[3]), 64'(17'h00000));
        end

        // single op with carry out from requester 2
        bus.req_A[47:32] = 16'hFFFF;
        bus.req_B[47:32] = 16'h0001;
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = '0;
        repeat (3) tick();
        chk("single_rsp_valid", 64'(bus.rsp_valid), 64'(4'b0100));
        chk("single_rsp_data", 64'(bus.rsp_data), 64'(17'h10000));
        chk("single_op_count", 64'(op_count), 64'd9);
        tick();

        // sparse fairness: move ptr to 2 via requester 1, then 1 and 3 alternate
        dut_grants.delete();
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = 4'b1010;
        repeat (6) tick();
        bus.req_valid = '0;
        repeat (4) tick();
        exp_g = '{1, 3, 1, 3, 1, 3, 1};
        chk_grants("sparse_grant", exp_g);

        // hold for three cycles in the middle of a stream
        dut_grants.delete();
        dut_rsp_oh.delete();
        bus.req_valid = 4'hF;
        repeat (2) tick();
        hold = 1'b1;
        #1;
        chk("hold_ready_zero", 64'(bus.req_ready), 64'd0);
        repeat (3) tick();
        hold = 1'b0;
        repeat (2) tick();
        bus.req_valid = '0;
        repeat (4) tick();
        exp_g = '{2, 3, 0, 1};
        chk_grants("hold_grant", exp_g);
        chk("hold_rsp_count", 64'(dut_rsp_oh.size()), 64'd4);
        if (dut_rsp_oh.size() >= 2) begin
            chk("hold_rsp_oh0", 64'(dut_rsp_oh[0]), 64'(4'b0100));
            chk("hold_rsp_oh1", 64'(dut_rsp_oh[1]), 64'(4'b1000));
        end

        // reset one cycle after two issues: in-flight work is dropped
        bus.req_valid = 4'hF;
        repeat (2) tick();
        bus.req_valid = '0;
        reset_n = 1'b0;
        tick();
        chk("rst_op_count", 64'(op_count), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_add_A", 64'(add_A), 64'd0);
        dut_rsp_oh.delete();
        en_cnt = 0;
        reset_n = 1'b1;
        bus.req_valid = 4'hF;
        repeat (5) tick();
        chk("restart_first_grant", 64'(bus.req_ready), 64'(4'b0001));
        chk("restart_enable_pulses", 64'(en_cnt), 64'd1);
        chk("restart_no_stale_rsp", 64'(dut_rsp_oh.size()), 64'd0);
        bus.req_valid = '0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
